// File: rtl/fifo_wr_arb.sv
// Packet-locking round-robin arbiter that merges NUM_IN requesters onto one FIFO write port.
// A grant is held until eop is accepted or the granted requester stays idle for TIMEOUT cycles.
module fifo_wr_arb #(
  parameter int unsigned NUM_IN   = 4,
  parameter int unsigned DAT_BITS = 8,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NUM_IN-1:0]                  i_val,
  input  logic [NUM_IN-1:0][DAT_BITS-1:0]    i_dat,
  input  logic [NUM_IN-1:0]                  i_eop,
  output logic [NUM_IN-1:0]                  o_rdy,
  output logic                               o_val,
  output logic [DAT_BITS-1:0]                o_dat,
  output logic                               o_eop,
  output logic [$clog2(NUM_IN)-1:0]          o_src,
  input  logic                               i_rdy,
  output logic                               o_timeout
);

  localparam int unsigned IW = $clog2(NUM_IN);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e                state_q;
  logic [IW-1:0]         grant_q;
  logic [IW-1:0]         last_q;
  logic [CW-1:0]         cnt_q;
  logic                  val_q;
  logic [DAT_BITS-1:0]   dat_q;
  logic                  eop_q;
  logic [IW-1:0]         src_q;
  logic                  to_q;

  logic [IW-1:0]         sel_c;
  logic [IW-1:0]         idx_c;
  logic                  found_c;
  logic                  gval_c;
  logic                  geop_c;
  logic                  rdy_g_c;
  logic                  req_xfer_c;
  logic                  out_xfer_c;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    sel_c   = '0;
    idx_c   = '0;
    found_c = 1'b0;
    for (int unsigned i = 1; i <= NUM_IN; i++) begin
      idx_c = IW'((32'(last_q) + i) % NUM_IN);
      if (!found_c && i_val[idx_c]) begin
        found_c = 1'b1;
        sel_c   = idx_c;
      end
    end
  end

  assign gval_c     = i_val[grant_q];
  assign geop_c     = i_eop[grant_q];
  assign rdy_g_c    = (state_q == LOCK) && (!val_q || i_rdy);
  assign req_xfer_c = gval_c && rdy_g_c;
  assign out_xfer_c = val_q && i_rdy;

  always_comb begin
    o_rdy          = '0;
    o_rdy[grant_q] = rdy_g_c;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_IN - 1);
      cnt_q   <= '0;
      val_q   <= 1'b0;
      dat_q   <= '0;
      eop_q   <= 1'b0;
      src_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      to_q <= 1'b0;

      // Single output register: reload on accept, otherwise clear once drained
      if (req_xfer_c) begin
        val_q <= 1'b1;
        dat_q <= i_dat[grant_q];
        eop_q <= geop_c;
        src_q <= grant_q;
      end else if (out_xfer_c) begin
        val_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (found_c) begin
            state_q <= LOCK;
            grant_q <= sel_c;
            cnt_q   <= '0;
          end
        end
        LOCK: begin
          if (req_xfer_c) begin
            cnt_q <= '0;
            if (geop_c) begin
              state_q <= IDLE;
              last_q  <= grant_q;
            end
          end else if (!gval_c) begin
            // Idle granted requester: count toward forced release
            if (cnt_q == CW'(TIMEOUT - 1)) begin
              state_q <= IDLE;
              last_q  <= grant_q;
              to_q    <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_val     = val_q;
  assign o_dat     = dat_q;
  assign o_eop     = eop_q;
  assign o_src     = src_q;
  assign o_timeout = to_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: packet sources with handshake, output capture, hand-computed expectations.
module tb_fifo_wr_arb;

  logic             clk;
  logic             i_rst;
  logic [3:0]       i_val;
  logic [3:0][7:0]  i_dat;
  logic [3:0]       i_eop;
  logic [3:0]       o_rdy;
  logic             o_val;
  logic [7:0]       o_dat;
  logic             o_eop;
  logic [1:0]       o_src;
  logic             i_rdy;
  logic             o_timeout;

  fifo_wr_arb #(.NUM_IN(4), .DAT_BITS(8), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_val(i_val), .i_dat(i_dat), .i_eop(i_eop),
    .o_rdy(o_rdy), .o_val(o_val), .o_dat(o_dat), .o_eop(o_eop), .o_src(o_src),
    .i_rdy(i_rdy), .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int src; int dat; int eop; int cyc;} rec_t;
  rec_t q[$];

  int         n_chk;
  int         n_fail;
  int         cyc;
  logic [3:0] en;
  int         plen[4];
  int         widx[4];
  int         stall_at[4];
  logic [3:0] last_fire;
  logic       toggle_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      i_val[k] = en[k] && (widx[k] < plen[k]) && (widx[k] != stall_at[k]);
      i_dat[k] = 8'(k * 16 + widx[k]);
      i_eop[k] = (widx[k] == plen[k] - 1);
    end
  endtask

  // One clock: capture handshakes before the edge, advance sources after it
  task automatic step();
    logic [3:0] f;
    f = i_val & o_rdy;
    if (o_val && i_rdy)
      q.push_back('{src: int'(o_src), dat: int'(o_dat), eop: int'(o_eop), cyc: cyc});
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) if (f[k]) widx[k]++;
    last_fire = f;
    if (toggle_rdy) i_rdy = ~i_rdy;
    drive();
    #1;
  endtask

  task automatic arm(input int k, input int len, input int stall);
    plen[k]     = len;
    widx[k]     = 0;
    stall_at[k] = stall;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    int fire_cyc;
    int to_cyc;
    int first_cyc;
    logic [11:0] vmask;

    n_chk = 0; n_fail = 0; cyc = 0;
    en = '0; i_rdy = 1'b1; toggle_rdy = 1'b0; i_rst = 1'b1;
    for (int k = 0; k < 4; k++) arm(k, 0, -1);
    drive();

    // Reset state
    do_reset();
    chk("rst_o_val", 32'(o_val), 0);
    chk("rst_o_rdy", 32'(o_rdy), 0);
    chk("rst_o_src", 32'(o_src), 0);
    chk("rst_o_dat", 32'(o_dat), 0);
    chk("rst_o_eop", 32'(o_eop), 0);
    chk("rst_o_timeout", 32'(o_timeout), 0);

    // All four requesters, 2-word packets, round-robin from 0
    for (int k = 0; k < 4; k++) arm(k, 2, -1);
    en = 4'b1111; q.delete(); drive();
    for (int s = 0; s < 30; s++) step();
    chk("rr_count", 32'(q.size()), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < q.size()) begin
        chk($sformatf("rr_src%0d", i), 32'(q[i].src), 32'(i / 2));
        chk($sformatf("rr_dat%0d", i), 32'(q[i].dat), 32'((i / 2) * 16 + (i % 2)));
        chk($sformatf("rr_eop%0d", i), 32'(q[i].eop), 32'(i % 2));
      end
    end
    if (q.size() == 8) chk("rr_span", 32'(q[7].cyc - q[0].cyc), 10);

    // Requester 2, 4-word packet under toggling back-pressure
    en = 4'b0100; arm(2, 4, -1); q.delete();
    i_rdy = 1'b1; toggle_rdy = 1'b1; drive();
    for (int s = 0; s < 24; s++) step();
    toggle_rdy = 1'b0; i_rdy = 1'b1; drive();
    for (int s = 0; s < 4; s++) step();
    chk("bp_count", 32'(q.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < q.size()) begin
        chk($sformatf("bp_src%0d", i), 32'(q[i].src), 2);
        chk($sformatf("bp_dat%0d", i), 32'(q[i].dat), 32'(32 + i));
        chk($sformatf("bp_eop%0d", i), 32'(q[i].eop), 32'(i == 3));
      end
    end

    // Requester 1 stalls after word 0; requester 2 waits behind the lock
    arm(1, 3, 1); arm(2, 1, -1); en = 4'b0110; q.delete(); drive();
    fire_cyc = -1; to_cyc = -1;
    for (int s = 0; s < 60 && to_cyc < 0; s++) begin
      step();
      if (last_fire[1] && fire_cyc < 0) fire_cyc = cyc;
      if (o_timeout) to_cyc = cyc;
    end
    chk("to_seen", 32'(to_cyc >= 0), 1);
    chk("to_delay", 32'(to_cyc - fire_cyc), 16);
    step();
    chk("to_pulse_width", 32'(o_timeout), 0);
    for (int s = 0; s < 8; s++) step();
    chk("to_count", 32'(q.size()), 2);
    if (q.size() == 2) begin
      chk("to_w0_src", 32'(q[0].src), 1);
      chk("to_w0_eop", 32'(q[0].eop), 0);
      chk("to_next_src", 32'(q[1].src), 2);
      chk("to_next_dat", 32'(q[1].dat), 32'h20);
      chk("to_next_after", 32'(q[1].cyc >= to_cyc), 1);
    end
    en = '0; drive();

    // Reset in the middle of a 5-word packet
    do_reset();
    arm(1, 5, -1); en = 4'b0010; drive();
    for (int s = 0; s < 20 && widx[1] < 2; s++) step();
    chk("mid_reached_w2", 32'(widx[1]), 2);
    i_rst = 1'b1;
    step();
    chk("mid_rst_o_val", 32'(o_val), 0);
    chk("mid_rst_o_rdy", 32'(o_rdy), 0);
    i_rst = 1'b0;
    arm(1, 1, -1); arm(2, 1, -1); en = 4'b0110; q.delete(); drive();
    for (int s = 0; s < 15; s++) step();
    chk("mid_count", 32'(q.size()), 2);
    if (q.size() == 2) begin
      chk("mid_first_src", 32'(q[0].src), 1);
      chk("mid_first_dat", 32'(q[0].dat), 32'h10);
      chk("mid_second_src", 32'(q[1].src), 2);
    end
    en = '0; drive();

    // Only requester 3 with last=3 after reset: wrap-around grant
    do_reset();
    arm(3, 1, -1); en = 4'b1000; q.delete(); drive();
    for (int s = 0; s < 10; s++) step();
    chk("wrap_count", 32'(q.size()), 1);
    if (q.size() == 1) begin
      chk("wrap_src", 32'(q[0].src), 3);
      chk("wrap_dat", 32'(q[0].dat), 32'h30);
      chk("wrap_eop", 32'(q[0].eop), 1);
    end
    en = '0; drive();

    // Single requester 8-word packet: o_val high 2..9 cycles after i_val rises
    do_reset();
    step();
    arm(0, 8, -1); en = 4'b0001; q.delete(); drive();
    vmask = '0;
    for (int j = 0; j < 12; j++) begin
      step();
      vmask[j] = o_val;
    end
    chk("stream_o_val_mask", 32'(vmask), 32'h1FE);
    chk("stream_count", 32'(q.size()), 8);
    if (q.size() == 8) begin
      first_cyc = q[0].cyc;
      chk("stream_span", 32'(q[7].cyc - first_cyc), 7);
      chk("stream_last_dat", 32'(q[7].dat), 7);
      chk("stream_last_eop", 32'(q[7].eop), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
